// File: rtl/dmux_dispatch.sv
// dmux_dispatch: 2-entry FIFO feeding the 1-to-4 demux with per-channel delivered-word counters
module dmux_dispatch #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    input  logic          rr_mode,
    output logic [1:0]    sel,
    output logic [DW-1:0] din,
    output logic          out_valid,
    input  logic [3:0]    ch_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt3
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
    occ_t state, state_nx;
    logic [DW-1:0] d0, d1;
    logic [1:0] t0, t1, rr_ptr, dest;
    logic [CW-1:0] cnt [4];
    logic push, pop;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign sel       = out_valid ? t0 : '0;
    assign din       = out_valid ? d0 : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && ch_ready[t0];
    assign dest      = rr_mode ? rr_ptr : in_dest;
    assign cnt0      = cnt[0];
    assign cnt1      = cnt[1];
    assign cnt2      = cnt[2];
    assign cnt3      = cnt[3];
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY:   state_nx = push ? ONE : EMPTY;
            ONE:     state_nx = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            FULL:    state_nx = pop ? ONE : FULL;
            default: state_nx = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0     <= '0;
            d1     <= '0;
            t0     <= '0;
            t1     <= '0;
            rr_ptr <= '0;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            if (push && rr_mode) rr_ptr <= rr_ptr + 2'd1;
            if (pop) begin
                cnt[t0] <= cnt[t0] + CW'(1);
                d0      <= d1;
                t0      <= t1;
            end
            if (push && (state == EMPTY || (state == ONE && pop))) begin
                d0 <= in_data;
                t0 <= dest;
            end
            if (push && state == ONE && !pop) begin
                d1 <= in_data;
                t1 <= dest;
            end
        end
    end
endmodule
